// File: rtl/enemy_wave_pkg.sv
// Shared constants for the enemy wave sequencer: FSM encodings, default parameters, width helper.
package enemy_wave_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAW  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ERASE = 3'd3;
  localparam logic [2:0] ST_MOVE  = 3'd4;

  localparam int unsigned DEF_N_ENEMY      = 4;
  localparam int unsigned DEF_SPRITE_W     = 4;
  localparam int unsigned DEF_DELAY_CYCLES = 15;
  localparam int unsigned DEF_X_W          = 8;
  localparam int unsigned DEF_Y_W          = 7;
  localparam int unsigned DEF_Y_START      = 0;
  localparam int unsigned DEF_Y_END        = 110;
  localparam int unsigned DEF_Y_STEP       = 1;
  localparam int unsigned DEF_COLOUR_W     = 3;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// Pixel walker over one SPRITE_W x SPRITE_W sprite; wraps to 0 after the last pixel.
module sprite_scan_counter
  import enemy_wave_pkg::*;
#(
  parameter int unsigned SPRITE_W = DEF_SPRITE_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          clear,
  output logic [idx_bits(SPRITE_W)-1:0] col,
  output logic [idx_bits(SPRITE_W)-1:0] row,
  output logic                          last
);

  localparam int unsigned SB = idx_bits(SPRITE_W);
  localparam int unsigned PW = 2 * SB;
  localparam logic [PW-1:0] P_LAST = PW'(SPRITE_W * SPRITE_W - 1);

  logic [PW-1:0] pix;

  always_ff @(posedge clock) begin
    if (reset) begin
      pix <= '0;
    end else if (clear) begin
      pix <= '0;
    end else if (en) begin
      pix <= last ? '0 : pix + PW'(1);
    end
  end

  // SPRITE_W is a power of two, so the index splits cleanly into row:col.
  assign last = (pix == P_LAST);
  assign col  = pix[SB-1:0];
  assign row  = pix[PW-1:SB];

endmodule

// File: rtl/enemy_wave_sequencer.sv
// Time-multiplexes one VGA plot port across N_ENEMY sprites: draw, hold, erase, step down.
// Optional player overlap detection is built when ENEMY_WAVE_HIT_EN is defined.
module enemy_wave_sequencer
  import enemy_wave_pkg::*;
#(
  parameter int unsigned N_ENEMY      = DEF_N_ENEMY,
  parameter int unsigned SPRITE_W     = DEF_SPRITE_W,
  parameter int unsigned DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter int unsigned X_W          = DEF_X_W,
  parameter int unsigned Y_W          = DEF_Y_W,
  parameter int unsigned Y_START      = DEF_Y_START,
  parameter int unsigned Y_END        = DEF_Y_END,
  parameter int unsigned Y_STEP       = DEF_Y_STEP,
  parameter int unsigned COLOUR_W     = DEF_COLOUR_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [N_ENEMY-1:0]           ch_en,
  input  logic [X_W-1:0]               spawn_x,
  input  logic [COLOUR_W-1:0]          sprite_colour,
`ifdef ENEMY_WAVE_HIT_EN
  input  logic [X_W-1:0]               player_x,
  input  logic [Y_W-1:0]               player_y,
  output logic                         hit,
  output logic [idx_bits(N_ENEMY)-1:0] hit_ch,
`endif
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         plot,
  output logic [idx_bits(N_ENEMY)-1:0] active_ch,
  output logic                         frame_done
);

  localparam int unsigned CH_W      = idx_bits(N_ENEMY);
  localparam int unsigned SB        = idx_bits(SPRITE_W);
  localparam int unsigned WT_W      = idx_bits(DELAY_CYCLES);
  localparam int unsigned YA_W      = Y_W + 1;
  localparam int unsigned X_SPACING = (2 ** X_W) / N_ENEMY;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(N_ENEMY - 1);
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(DELAY_CYCLES - 1);
  localparam logic [YA_W-1:0] Y_END_A = YA_W'(Y_END);

  logic [2:0]         state, state_next;
  logic [CH_W-1:0]    ch, ch_next;
  logic [WT_W-1:0]    wait_cnt, wait_next;
  logic [N_ENEMY-1:0] frame_en;
  logic               latch_en;

  logic [X_W-1:0]  xpos  [N_ENEMY];
  logic [Y_W-1:0]  ypos  [N_ENEMY];
  logic [YA_W-1:0] y_adv [N_ENEMY];

  logic          scanning, cur_en, scan_en, scan_clr, ch_done;
  logic [SB-1:0] col, row;
  logic          pix_last;

  assign scanning = (state == ST_DRAW) || (state == ST_ERASE);
  assign cur_en   = frame_en[ch];
  assign scan_en  = scanning && cur_en;
  assign scan_clr = !scanning;
  // A disabled channel occupies exactly one scan slot.
  assign ch_done  = !cur_en || pix_last;

  sprite_scan_counter #(
    .SPRITE_W (SPRITE_W)
  ) u_scan (
    .clock (clock),
    .reset (reset),
    .en    (scan_en),
    .clear (scan_clr),
    .col   (col),
    .row   (row),
    .last  (pix_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      ch       <= '0;
      wait_cnt <= '0;
      frame_en <= '0;
    end else begin
      state    <= state_next;
      ch       <= ch_next;
      wait_cnt <= wait_next;
      if (latch_en) begin
        frame_en <= ch_en;
      end
    end
  end

  always_comb begin
    state_next = state;
    ch_next    = ch;
    wait_next  = '0;
    latch_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next = ST_DRAW;
          latch_en   = 1'b1;
        end
      end
      ST_DRAW, ST_ERASE: begin
        if (ch_done) begin
          if (ch == CH_LAST) begin
            ch_next    = '0;
            state_next = (state == ST_DRAW) ? ST_WAIT : ST_MOVE;
          end else begin
            ch_next = ch + CH_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == WT_LAST) begin
          state_next = ST_ERASE;
        end else begin
          wait_next = wait_cnt + WT_W'(1);
        end
      end
      ST_MOVE: begin
        if (enable) begin
          state_next = ST_DRAW;
          latch_en   = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Widened by one bit so the respawn compare cannot be fooled by wrap-around.
  always_comb begin
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      y_adv[i] = {1'b0, ypos[i]} + YA_W'(Y_STEP);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        xpos[i] <= X_W'(i * X_SPACING);
        ypos[i] <= Y_W'(Y_START);
      end
    end else if (state == ST_MOVE) begin
      for (int unsigned i = 0; i < N_ENEMY; i++) begin
        if (frame_en[i]) begin
          if (y_adv[i] >= Y_END_A) begin
            ypos[i] <= Y_W'(Y_START);
            xpos[i] <= spawn_x;
          end else begin
            ypos[i] <= y_adv[i][Y_W-1:0];
          end
        end
      end
    end
  end

  assign plot       = scan_en;
  assign active_ch  = ch;
  assign frame_done = (state == ST_MOVE);

  always_comb begin
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    if (scan_en) begin
      vga_x = xpos[ch] + X_W'(col);
      vga_y = ypos[ch] + Y_W'(row);
      if (state == ST_DRAW) begin
        vga_colour = sprite_colour;
      end
    end
  end

`ifdef ENEMY_WAVE_HIT_EN
  logic [X_W-1:0]     dx [N_ENEMY];
  logic [Y_W-1:0]     dy [N_ENEMY];
  logic [N_ENEMY-1:0] near;
  logic               near_any;
  logic [CH_W-1:0]    near_idx;

  // Absolute distances on the positions as they stand before the MOVE update.
  always_comb begin
    for (int unsigned i = 0; i < N_ENEMY; i++) begin
      dx[i]   = (xpos[i] >= player_x) ? xpos[i] - player_x : player_x - xpos[i];
      dy[i]   = (ypos[i] >= player_y) ? ypos[i] - player_y : player_y - ypos[i];
      near[i] = frame_en[i] && (dx[i] < X_W'(SPRITE_W)) && (dy[i] < Y_W'(SPRITE_W));
    end
  end

  // Descending scan so the lowest overlapping channel wins.
  always_comb begin
    near_any = 1'b0;
    near_idx = '0;
    for (int i = int'(N_ENEMY) - 1; i >= 0; i--) begin
      if (near[i]) begin
        near_any = 1'b1;
        near_idx = CH_W'(i);
      end
    end
  end

  assign hit    = (state == ST_MOVE) && near_any;
  assign hit_ch = (state == ST_MOVE) ? near_idx : '0;
`else
  // No overlap detection in this build; positions feed only the plot path.
`endif

endmodule
